// File: rtl/sync_mem_pkg.sv
// Shared types and constants for the synchronous memory family.
// Holds the read-during-write policy enum and the byte-lane width.
package sync_mem_pkg;

  typedef enum logic {
    READ_FIRST,
    WRITE_FIRST
  } rw_mode_e;

  localparam int BYTE = 8;

endpackage

// File: rtl/sync_dp_mem_if.sv
// Write/read port bundle of the simple dual-port memory.
// The master drives requests; the slave returns registered read data.
interface sync_dp_mem_if
  import sync_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
);

  logic                    writeEnable;
  logic [ADDR_WIDTH-1:0]   writeAddress;
  logic [WIDTH-1:0]        writeData;
  logic [WIDTH/BYTE-1:0]   byteEnable;
  logic                    readEnable;
  logic [ADDR_WIDTH-1:0]   readAddress;
  logic [WIDTH-1:0]        readData;
  logic                    readValid;

  modport master (
    output writeEnable, writeAddress, writeData, byteEnable,
    output readEnable, readAddress,
    input  readData, readValid
  );

  modport slave (
    input  writeEnable, writeAddress, writeData, byteEnable,
    input  readEnable, readAddress,
    output readData, readValid
  );

endinterface

// File: rtl/sync_dp_mem.sv
// Simple dual-port synchronous RAM: one byte-masked write port, one read port
// with 1- or 2-cycle fully pipelined latency and a selectable collision policy.
module sync_dp_mem
  import sync_mem_pkg::*;
#(
  parameter int       ADDR_WIDTH   = 4,
  parameter int       WIDTH        = 8,
  parameter int       READ_LATENCY = 1,
  parameter rw_mode_e RW_MODE      = READ_FIRST
) (
  input logic          clk,
  input logic          rstN,
  sync_dp_mem_if.slave bus
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = WIDTH / BYTE;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sync_dp_mem: READ_LATENCY must be 1 or 2");
  end
  if (RW_MODE != READ_FIRST && RW_MODE != WRITE_FIRST) begin : g_bad_mode
    $error("sync_dp_mem: RW_MODE must be READ_FIRST or WRITE_FIRST");
  end
  if (WIDTH <= 0 || (WIDTH % BYTE) != 0) begin : g_bad_width
    $error("sync_dp_mem: WIDTH must be a positive multiple of 8");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [WIDTH-1:0] rd_word;

  // Requests presented while reset is held must not touch the array.
  assign wr_en = bus.writeEnable && rstN;

  // NOTE: the array is deliberately left out of reset so it maps onto block
  // RAM; its contents survive rstN and are undefined after power-up.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.byteEnable[i]) begin
          mem[bus.writeAddress][i*BYTE +: BYTE] <= bus.writeData[i*BYTE +: BYTE];
        end
      end
    end
  end

  // Stage-1 read word; WRITE_FIRST overlays the bytes being written this cycle.
  always_comb begin
    rd_word = mem[bus.readAddress];
    if (RW_MODE == WRITE_FIRST && wr_en && bus.writeAddress == bus.readAddress) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.byteEnable[i]) begin
          rd_word[i*BYTE +: BYTE] = bus.writeData[i*BYTE +: BYTE];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        bus.readData  <= '0;
        bus.readValid <= 1'b0;
      end else begin
        bus.readValid <= bus.readEnable;
        if (bus.readEnable) begin
          bus.readData <= rd_word;
        end
      end
    end

  end else begin : g_lat2

    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    // Capture happens at the accepting edge, so a write one cycle later
    // cannot leak into this result.
    always_ff @(posedge clk) begin
      if (bus.readEnable) begin
        s1_data <= rd_word;
      end
    end

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        s1_valid      <= 1'b0;
        bus.readData  <= '0;
        bus.readValid <= 1'b0;
      end else begin
        s1_valid      <= bus.readEnable;
        bus.readValid <= s1_valid;
        if (s1_valid) begin
          bus.readData <= s1_data;
        end
      end
    end

  end

endmodule

// File: tb/tb_sync_dp_mem.sv
// Directed bench: two instances share stimulus, one READ_FIRST with latency 1
// and one WRITE_FIRST with latency 2, both 32 bits wide.
module tb_sync_dp_mem;
  import sync_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        re;
  logic [3:0]  ra;

  int checks = 0;
  int errors = 0;

  sync_dp_mem_if #(.ADDR_WIDTH(4), .WIDTH(32)) bus1 ();
  sync_dp_mem_if #(.ADDR_WIDTH(4), .WIDTH(32)) bus2 ();

  assign bus1.writeEnable  = we;
  assign bus1.writeAddress = wa;
  assign bus1.writeData    = wd;
  assign bus1.byteEnable   = be;
  assign bus1.readEnable   = re;
  assign bus1.readAddress  = ra;
  assign bus2.writeEnable  = we;
  assign bus2.writeAddress = wa;
  assign bus2.writeData    = wd;
  assign bus2.byteEnable   = be;
  assign bus2.readEnable   = re;
  assign bus2.readAddress  = ra;

  sync_dp_mem #(
    .ADDR_WIDTH(4), .WIDTH(32), .READ_LATENCY(1), .RW_MODE(READ_FIRST)
  ) dut1 (
    .clk (clk),
    .rstN(rstN),
    .bus (bus1)
  );

  sync_dp_mem #(
    .ADDR_WIDTH(4), .WIDTH(32), .READ_LATENCY(2), .RW_MODE(WRITE_FIRST)
  ) dut2 (
    .clk (clk),
    .rstN(rstN),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wa = a; wd = d; be = m;
    tick();
    we = 1'b0; be = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0;
  endtask

  task automatic test_reset();
    re = 1'b1; ra = 4'd0;
    tick();
    tick();
    checks++;
    if ({bus1.readValid, bus1.readData} !== 33'h0) begin
      errors++;
      $display("FAIL reset_lat1: got v=%b d=%h expected v=0 d=0", bus1.readValid, bus1.readData);
    end
    checks++;
    if ({bus2.readValid, bus2.readData} !== 33'h0) begin
      errors++;
      $display("FAIL reset_lat2: got v=%b d=%h expected v=0 d=0", bus2.readValid, bus2.readData);
    end
    re = 1'b0;
    rstN = 1'b1;
    tick();
    checks++;
    if ({bus1.readValid, bus2.readValid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_valid: got %b expected 00", {bus1.readValid, bus2.readValid});
    end
  endtask

  task automatic test_write_read();
    wr(4'd3, 32'h0000_00A5, 4'hF);
    rd(4'd3);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL wr_rd_lat1: got v=%b d=%h expected v=1 d=000000a5", bus1.readValid, bus1.readData);
    end
    checks++;
    if (bus2.readValid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_lat2_early: got v=%b expected v=0", bus2.readValid);
    end
    tick();
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b0, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL wr_rd_lat1_hold: got v=%b d=%h expected v=0 d=000000a5", bus1.readValid, bus1.readData);
    end
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL wr_rd_lat2: got v=%b d=%h expected v=1 d=000000a5", bus2.readValid, bus2.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b0, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL wr_rd_lat2_hold: got v=%b d=%h expected v=0 d=000000a5", bus2.readValid, bus2.readData);
    end
  endtask

  task automatic test_byte_enable();
    wr(4'd5, 32'h1122_3344, 4'hF);
    wr(4'd5, 32'hAABB_CCDD, 4'b0101);
    wr(4'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd5);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h11BB_33DD}) begin
      errors++;
      $display("FAIL byte_en_lat1: got v=%b d=%h expected v=1 d=11bb33dd", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h11BB_33DD}) begin
      errors++;
      $display("FAIL byte_en_lat2: got v=%b d=%h expected v=1 d=11bb33dd", bus2.readValid, bus2.readData);
    end
  endtask

  task automatic test_collision();
    wr(4'd7, 32'h0000_0010, 4'hF);
    we = 1'b1; wa = 4'd7; wd = 32'h0000_0020; be = 4'hF;
    re = 1'b1; ra = 4'd7;
    tick();
    we = 1'b0; be = 4'h0; re = 1'b0;
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_0010}) begin
      errors++;
      $display("FAIL collide_read_first: got v=%b d=%h expected v=1 d=00000010", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_0020}) begin
      errors++;
      $display("FAIL collide_write_first: got v=%b d=%h expected v=1 d=00000020", bus2.readValid, bus2.readData);
    end
    // Partial write colliding with the read: only the upper two bytes change.
    we = 1'b1; wa = 4'd7; wd = 32'hCAFE_0000; be = 4'b1100;
    re = 1'b1; ra = 4'd7;
    tick();
    we = 1'b0; be = 4'h0; re = 1'b0;
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_0020}) begin
      errors++;
      $display("FAIL collide_partial_rf: got v=%b d=%h expected v=1 d=00000020", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'hCAFE_0020}) begin
      errors++;
      $display("FAIL collide_partial_wf: got v=%b d=%h expected v=1 d=cafe0020", bus2.readValid, bus2.readData);
    end
    rd(4'd7);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'hCAFE_0020}) begin
      errors++;
      $display("FAIL collide_stored_lat1: got v=%b d=%h expected v=1 d=cafe0020", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'hCAFE_0020}) begin
      errors++;
      $display("FAIL collide_stored_lat2: got v=%b d=%h expected v=1 d=cafe0020", bus2.readValid, bus2.readData);
    end
    // Different addresses in the same cycle proceed independently.
    we = 1'b1; wa = 4'd8; wd = 32'h0000_0088; be = 4'hF;
    re = 1'b1; ra = 4'd3;
    tick();
    we = 1'b0; be = 4'h0; re = 1'b0;
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL diff_addr_lat1: got v=%b d=%h expected v=1 d=000000a5", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL diff_addr_lat2: got v=%b d=%h expected v=1 d=000000a5", bus2.readValid, bus2.readData);
    end
    rd(4'd8);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_0088}) begin
      errors++;
      $display("FAIL diff_addr_wr_lat1: got v=%b d=%h expected v=1 d=00000088", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_0088}) begin
      errors++;
      $display("FAIL diff_addr_wr_lat2: got v=%b d=%h expected v=1 d=00000088", bus2.readValid, bus2.readData);
    end
  endtask

  task automatic test_stage1_capture();
    rd(4'd3);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL capture_lat1: got v=%b d=%h expected v=1 d=000000a5", bus1.readValid, bus1.readData);
    end
    wr(4'd3, 32'h0000_0033, 4'hF);
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_00A5}) begin
      errors++;
      $display("FAIL capture_lat2: got v=%b d=%h expected v=1 d=000000a5", bus2.readValid, bus2.readData);
    end
    rd(4'd3);
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_0033}) begin
      errors++;
      $display("FAIL capture_after_wr: got v=%b d=%h expected v=1 d=00000033", bus2.readValid, bus2.readData);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'h0000_1000 + 32'(i);
      wr(4'(i), vals[i], 4'hF);
    end
    re = 1'b1; ra = 4'd0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 3) ra = 4'(c + 1);
      else       re = 1'b0;
      checks++;
      if ({bus1.readValid, bus1.readData} !== {(c < 4), vals[(c < 3) ? c : 3]}) begin
        errors++;
        $display("FAIL b2b_lat1 cycle %0d: got v=%b d=%h expected v=%b d=%h",
                 c, bus1.readValid, bus1.readData, (c < 4), vals[(c < 3) ? c : 3]);
      end
      if (c >= 1) begin
        checks++;
        if ({bus2.readValid, bus2.readData} !== {(c < 5), vals[(c < 4) ? c - 1 : 3]}) begin
          errors++;
          $display("FAIL b2b_lat2 cycle %0d: got v=%b d=%h expected v=%b d=%h",
                   c, bus2.readValid, bus2.readData, (c < 5), vals[(c < 4) ? c - 1 : 3]);
        end
      end else begin
        checks++;
        if (bus2.readValid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_lat2_first: got v=%b expected v=0", bus2.readValid);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    wr(4'd9, 32'h0000_0099, 4'hF);
    rd(4'd9);
    rstN = 1'b0;
    we = 1'b1; wa = 4'd9; wd = 32'h0000_DEAD; be = 4'hF;
    re = 1'b1; ra = 4'd9;
    #1;
    checks++;
    if ({bus1.readValid, bus1.readData, bus2.readValid, bus2.readData} !== 66'h0) begin
      errors++;
      $display("FAIL rst_mid_immediate: got v1=%b d1=%h v2=%b d2=%h expected all 0",
               bus1.readValid, bus1.readData, bus2.readValid, bus2.readData);
    end
    tick();
    tick();
    checks++;
    if ({bus1.readValid, bus1.readData, bus2.readValid, bus2.readData} !== 66'h0) begin
      errors++;
      $display("FAIL rst_mid_held: got v1=%b d1=%h v2=%b d2=%h expected all 0",
               bus1.readValid, bus1.readData, bus2.readValid, bus2.readData);
    end
    we = 1'b0; be = 4'h0; re = 1'b0;
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bus1.readValid, bus2.readValid} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_no_valid cycle %0d: got %b expected 00", c, {bus1.readValid, bus2.readValid});
      end
    end
    rd(4'd9);
    checks++;
    if ({bus1.readValid, bus1.readData} !== {1'b1, 32'h0000_0099}) begin
      errors++;
      $display("FAIL rst_retain_lat1: got v=%b d=%h expected v=1 d=00000099", bus1.readValid, bus1.readData);
    end
    tick();
    checks++;
    if ({bus2.readValid, bus2.readData} !== {1'b1, 32'h0000_0099}) begin
      errors++;
      $display("FAIL rst_retain_lat2: got v=%b d=%h expected v=1 d=00000099", bus2.readValid, bus2.readData);
    end
  endtask

  initial begin
    rstN = 1'b0;
    we = 1'b0; wa = '0; wd = '0; be = '0;
    re = 1'b0; ra = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_stage1_capture();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
